// File: rtl/serdes_pkg.sv
// -----------------------------------------------------------------------------
// serdes_pkg
// Definitions shared by the serial transmitter and the matching receivers.
//   IDLE / SHIFT : transmitter state encodings
//   PARITY_ODD   : parity polarity (0 = even parity), shared with the receiver
//   cnt_width()  : width of a down-counter that must hold values 0..nbits
// -----------------------------------------------------------------------------
package serdes_pkg;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic PARITY_ODD = 1'b0;

    function automatic int cnt_width(input int nbits);
        return $clog2(nbits + 1);
    endfunction

endpackage

// File: rtl/parity_calc.sv
// -----------------------------------------------------------------------------
// parity_calc
// XOR reduction of a WIDTH-bit word.
//   data   : word to reduce
//   parity : XOR of all bits of data (1 when data has an odd number of ones)
// -----------------------------------------------------------------------------
module parity_calc #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic             parity
);

    assign parity = ^data;

endmodule

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
// Parallel-in, serial-out transmitter. Takes a WIDTH-bit word over a
// valid/ready handshake and sends it one bit per clock, MSB or LSB first.
// Optional feature macro: PISO_PARITY_EN -- appends an even parity bit after
// the last data bit (NBITS = WIDTH+1); undefined gives NBITS = WIDTH.
//
// Ports:
//   clock      : rising-edge clock
//   clear      : asynchronous active-high reset
//   load_data  : word to transmit
//   load_valid : load_data is valid
//   load_ready : word can be accepted this cycle (idle or last bit)
//   ser_out    : serial data bit (0 when ser_valid is 0)
//   ser_valid  : ser_out carries a valid bit
//   ser_last   : current bit is the final bit of the word
//   busy       : a word is in transmission
// -----------------------------------------------------------------------------
module piso_serializer
    import serdes_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

`ifdef PISO_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int CW = cnt_width(NBITS);

    logic [0:0]       state;
    logic [NBITS-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [NBITS-1:0] load_word;
    logic             last_bit;
    logic             take;
    logic             head;

`ifdef PISO_PARITY_EN
    logic par_raw;
    logic par_bit;

    parity_calc #(.WIDTH(WIDTH)) u_parity (
        .data   (load_data),
        .parity (par_raw)
    );

    assign par_bit = par_raw ^ PARITY_ODD;

    // Parity sits at the tail end of the register so it leaves after the
    // final data bit in either shift direction.
    assign load_word = MSB_FIRST ? {load_data, par_bit} : {par_bit, load_data};
`else
    assign load_word = load_data;
`endif

    // All outputs decode from state/counter/register only.
    assign last_bit   = (state == SHIFT) && (cnt == '0);
    assign load_ready = (state == IDLE) || last_bit;
    assign take       = load_valid && load_ready;
    assign head       = MSB_FIRST ? shreg[NBITS-1] : shreg[0];

    assign busy       = (state == SHIFT);
    assign ser_valid  = (state == SHIFT);
    assign ser_last   = last_bit;
    assign ser_out    = (state == SHIFT) && head;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else if (take) begin
            state <= SHIFT;
            shreg <= load_word;
            cnt   <= CW'(NBITS - 1);
        end else if (state == SHIFT) begin
            shreg <= MSB_FIRST ? {shreg[NBITS-2:0], 1'b0} : {1'b0, shreg[NBITS-1:1]};
            if (cnt == '0) begin
                state <= IDLE;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
// Bench for piso_serializer: one MSB-first and one LSB-first instance
// (WIDTH=8). Drivers push expected bit streams into per-instance queues;
// monitors compare every cycle after the clock edge.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    typedef struct packed {
        logic d;
        logic last;
    } exp_t;

    logic       clock = 1'b0;
    logic       clear;
    logic [7:0] data_m, data_l;
    logic       valid_m, valid_l;
    logic       ready_m, out_m, sv_m, last_m, busy_m;
    logic       ready_l, out_l, sv_l, last_l, busy_l;

    exp_t q_m[$];
    exp_t q_l[$];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clock      (clock),
        .clear      (clear),
        .load_data  (data_m),
        .load_valid (valid_m),
        .load_ready (ready_m),
        .ser_out    (out_m),
        .ser_valid  (sv_m),
        .ser_last   (last_m),
        .busy       (busy_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clock      (clock),
        .clear      (clear),
        .load_data  (data_l),
        .load_valid (valid_l),
        .load_ready (ready_l),
        .ser_out    (out_l),
        .ser_valid  (sv_l),
        .ser_last   (last_l),
        .busy       (busy_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: a pending expectation demands a valid bit this cycle, which
    // catches both late first bits and gaps between back-to-back words.
    always @(posedge clock) begin : mon_m
        exp_t e;
        #1;
        if (!clear) begin
            if (sv_m) begin
                if (q_m.size() == 0) begin
                    check("m_unexpected_valid", 32'(sv_m), 32'd0);
                end else begin
                    e = q_m.pop_front();
                    check("m_ser_out", 32'(out_m), 32'(e.d));
                    check("m_ser_last", 32'(last_m), 32'(e.last));
                    check("m_busy", 32'(busy_m), 32'd1);
                end
            end else if (q_m.size() != 0) begin
                check("m_ser_valid", 32'(sv_m), 32'd1);
            end else begin
                check("m_idle_outs", {29'd0, out_m, last_m, busy_m}, 32'd0);
            end
        end
    end

    always @(posedge clock) begin : mon_l
        exp_t e;
        #1;
        if (!clear) begin
            if (sv_l) begin
                if (q_l.size() == 0) begin
                    check("l_unexpected_valid", 32'(sv_l), 32'd0);
                end else begin
                    e = q_l.pop_front();
                    check("l_ser_out", 32'(out_l), 32'(e.d));
                    check("l_ser_last", 32'(last_l), 32'(e.last));
                    check("l_busy", 32'(busy_l), 32'd1);
                end
            end else if (q_l.size() != 0) begin
                check("l_ser_valid", 32'(sv_l), 32'd1);
            end else begin
                check("l_idle_outs", {29'd0, out_l, last_l, busy_l}, 32'd0);
            end
        end
    end

    // Called at a falling edge. seq holds the hand-computed bits in send
    // order (seq[7] first); par is the hand-computed even parity bit.
    // With junk set, load_data carries a decoy word until load_ready rises.
    task automatic send(input bit sel, input logic [7:0] data, input logic [7:0] seq,
                        input logic par, input bit junk);
        int   tries = 0;
        exp_t e;
        if (sel) begin
            valid_l = 1'b1;
            data_l  = junk ? 8'h3C : data;
        end else begin
            valid_m = 1'b1;
            data_m  = junk ? 8'h3C : data;
        end
        while (!(sel ? ready_l : ready_m)) begin
            @(negedge clock);
            tries++;
            if (tries > 100) begin
                vectors++;
                miscompares++;
                $display("FAIL handshake_timeout: load_ready still 0 after %0d cycles", tries);
                return;
            end
        end
        if (sel) data_l = data;
        else     data_m = data;
        for (int i = 0; i < 8; i++) begin
            e.d    = seq[7-i];
            e.last = (NB == 8) && (i == 7);
            if (sel) q_l.push_back(e);
            else     q_m.push_back(e);
        end
        if (NB == 9) begin
            e.d    = par;
            e.last = 1'b1;
            if (sel) q_l.push_back(e);
            else     q_m.push_back(e);
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drain();
        int n = 0;
        while (q_m.size() != 0 || q_l.size() != 0 || busy_m || busy_l) begin
            @(negedge clock);
            n++;
            if (n > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL drain_timeout: queues %0d/%0d busy %0b/%0b",
                         q_m.size(), q_l.size(), busy_m, busy_l);
                return;
            end
        end
        @(negedge clock);
    endtask

    initial begin
        clear   = 1'b1;
        valid_m = 1'b0;
        valid_l = 1'b0;
        data_m  = '0;
        data_l  = '0;
        #1;
        check("reset_ready_m", 32'(ready_m), 32'd1);
        check("reset_outs_m", {28'd0, out_m, sv_m, last_m, busy_m}, 32'd0);
        check("reset_ready_l", 32'(ready_l), 32'd1);
        check("reset_outs_l", {28'd0, out_l, sv_l, last_l, busy_l}, 32'd0);
        repeat (2) @(negedge clock);
        clear = 1'b0;
        @(negedge clock);

        // Single word, MSB first: A5 -> 1,0,1,0,0,1,0,1 (4 ones, parity 0)
        send(1'b0, 8'hA5, 8'b10100101, 1'b0, 1'b0);
        valid_m = 1'b0;
        drain();

        // LSB first: 01 -> 1 then seven 0s (parity 1); 2C -> 0,0,1,1,0,1,0,0
        send(1'b1, 8'h01, 8'b10000000, 1'b1, 1'b0);
        valid_l = 1'b0;
        drain();
        send(1'b1, 8'h2C, 8'b00110100, 1'b1, 1'b0);
        valid_l = 1'b0;
        drain();

        // Back to back with load_valid held: FF then 00, no gap
        send(1'b0, 8'hFF, 8'b11111111, 1'b0, 1'b0);
        send(1'b0, 8'h00, 8'b00000000, 1'b0, 1'b0);
        valid_m = 1'b0;
        drain();

        // Stall: next word offered mid-word behind a decoy; 07 has parity 1
        send(1'b0, 8'h96, 8'b10010110, 1'b0, 1'b0);
        check("m_ready_midword", 32'(ready_m), 32'd0);
        send(1'b0, 8'h07, 8'b00000111, 1'b1, 1'b1);
        check("m_ready_midword2", 32'(ready_m), 32'd0);
        send(1'b0, 8'h03, 8'b00000011, 1'b0, 1'b1);
        valid_m = 1'b0;
        drain();

        // LSB-first stream of the parity words: 07 (parity 1), 03 (parity 0)
        send(1'b1, 8'h07, 8'b11100000, 1'b1, 1'b0);
        check("l_ready_midword", 32'(ready_l), 32'd0);
        send(1'b1, 8'h03, 8'b11000000, 1'b0, 1'b1);
        valid_l = 1'b0;
        drain();

        // Clear mid-word: outputs drop asynchronously, word does not resume
        send(1'b0, 8'hA5, 8'b10100101, 1'b0, 1'b0);
        valid_m = 1'b0;
        repeat (3) @(negedge clock);
        #2;
        clear = 1'b1;
        #1;
        check("clear_outs_m", {29'd0, sv_m, last_m, busy_m}, 32'd0);
        check("clear_serout_m", 32'(out_m), 32'd0);
        q_m.delete();
        @(negedge clock);
        clear = 1'b0;
        #1;
        check("post_clear_ready_m", 32'(ready_m), 32'd1);
        check("post_clear_busy_m", 32'(busy_m), 32'd0);
        @(negedge clock);
        repeat (10) @(negedge clock);
        send(1'b0, 8'h2C, 8'b00101100, 1'b1, 1'b0);
        valid_m = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
